// File: rtl/lsu_wb_stage.sv
// lsu_wb_stage: memory/writeback stage. Issues loads/stores on a req/ack bus,
// stalls upstream while an access is outstanding, aligns/extends load data and
// drives registered register-file write signals.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of forcing them aligned.
module lsu_wb_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reg_wr,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [1:0]  wb_sel,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd_addr,
   input  logic [31:0] alu_result,
   input  logic [31:0] rs2_data,
   input  logic [31:0] pc,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        bus_err,
   output logic        misalign_trap
);

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [3:0]       mem_be_q, mem_be_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic             rf_we_q, rf_we_d;
   logic [4:0]       rf_waddr_q, rf_waddr_d;
   logic [31:0]      rf_wdata_q, rf_wdata_d;
   logic             bus_err_q, bus_err_d;
   logic             misalign_trap_q, misalign_trap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // captured instruction context for the outstanding access
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      pc4_q, pc4_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [4:0]       rd_q, rd_d;
   logic             reg_wr_q, reg_wr_d;
   logic [1:0]       wb_sel_q, wb_sel_d;
   logic             is_load_q, is_load_d;
   logic             stall_c;
   logic             trap_hit;

   // effective byte offset: half forces a[0]=0, word forces a=00
   function automatic logic [1:0] eff_off(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         2'b00:   return a;
         2'b01:   return {a[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         2'b00:   return 4'b0001 << off;
         2'b01:   return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
      case (sz)
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[{off, 3'b000} +: 8];
      h = d[{off[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0, h};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] wb_val(input logic [1:0] sel, input logic [31:0] alu,
                                          input logic [31:0] pc4, input logic [31:0] ld);
      case (sel)
         2'b01:   return ld;
         2'b10:   return pc4;
         default: return alu;
      endcase
   endfunction

`ifdef MISALIGN_TRAP_EN
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
      return ((sz == 2'b01) && a[0]) || (sz[1] && (a != 2'b00));
   endfunction

   assign trap_hit = misaligned(funct3[1:0], alu_result[1:0]);
`else
   assign trap_hit = 1'b0;
`endif

   // next-state, bus and writeback computation
   always_comb begin
      state_d         = state_q;
      mem_req_d       = mem_req_q;
      mem_we_d        = mem_we_q;
      mem_be_d        = mem_be_q;
      mem_wdata_d     = mem_wdata_q;
      rf_we_d         = rf_we_q;
      rf_waddr_d      = rf_waddr_q;
      rf_wdata_d      = rf_wdata_q;
      bus_err_d       = 1'b0;
      misalign_trap_d = 1'b0;
      cnt_d           = cnt_q;
      addr_d          = addr_q;
      pc4_d           = pc4_q;
      funct3_d        = funct3_q;
      rd_d            = rd_q;
      reg_wr_d        = reg_wr_q;
      wb_sel_d        = wb_sel_q;
      is_load_d       = is_load_q;
      stall_c         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if ((wr_en || rd_en) && trap_hit) begin
               misalign_trap_d = 1'b1;
               rf_we_d         = 1'b0;
            end else if (wr_en || rd_en) begin
               stall_c     = 1'b1;
               addr_d      = alu_result;
               pc4_d       = pc + 32'd4;
               funct3_d    = funct3;
               rd_d        = rd_addr;
               reg_wr_d    = reg_wr;
               wb_sel_d    = wb_sel;
               is_load_d   = !wr_en;
               mem_req_d   = 1'b1;
               mem_we_d    = wr_en;
               mem_be_d    = store_be(funct3[1:0], eff_off(funct3[1:0], alu_result[1:0]));
               mem_wdata_d = store_data(funct3[1:0], rs2_data);
               rf_we_d     = 1'b0;
               cnt_d       = '0;
               state_d     = S_BUSY;
            end else begin
               rf_we_d    = reg_wr && (rd_addr != '0);
               rf_waddr_d = rd_addr;
               rf_wdata_d = wb_val(wb_sel, alu_result, pc + 32'd4, 32'h0);
            end
         end
         S_BUSY: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = S_IDLE;
               if (is_load_q) begin
                  rf_we_d    = reg_wr_q && (rd_q != '0);
                  rf_waddr_d = rd_q;
                  rf_wdata_d = wb_val(wb_sel_q, addr_q, pc4_q,
                                      load_data(funct3_q, eff_off(funct3_q[1:0], addr_q[1:0]),
                                                mem_rdata));
               end else begin
                  rf_we_d = 1'b0;
               end
            end else if (cnt_q == CNT_LAST) begin
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               rf_we_d   = 1'b0;
               state_d   = S_IDLE;
            end else begin
               stall_c = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // stall is forced low while reset is held so upstream is released at once
   assign stall         = stall_c && !rst;
   assign mem_req       = mem_req_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = {addr_q[31:2], 2'b00};
   assign mem_be        = mem_be_q;
   assign mem_wdata     = mem_wdata_q;
   assign rf_we         = rf_we_q;
   assign rf_waddr      = rf_waddr_q;
   assign rf_wdata      = rf_wdata_q;
   assign bus_err       = bus_err_q;
   assign misalign_trap = misalign_trap_q;

   // state and registered outputs, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         mem_req_q       <= 1'b0;
         mem_we_q        <= 1'b0;
         mem_be_q        <= '0;
         mem_wdata_q     <= '0;
         rf_we_q         <= 1'b0;
         rf_waddr_q      <= '0;
         rf_wdata_q      <= '0;
         bus_err_q       <= 1'b0;
         misalign_trap_q <= 1'b0;
         cnt_q           <= '0;
         addr_q          <= '0;
         pc4_q           <= '0;
         funct3_q        <= '0;
         rd_q            <= '0;
         reg_wr_q        <= 1'b0;
         wb_sel_q        <= '0;
         is_load_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         mem_req_q       <= mem_req_d;
         mem_we_q        <= mem_we_d;
         mem_be_q        <= mem_be_d;
         mem_wdata_q     <= mem_wdata_d;
         rf_we_q         <= rf_we_d;
         rf_waddr_q      <= rf_waddr_d;
         rf_wdata_q      <= rf_wdata_d;
         bus_err_q       <= bus_err_d;
         misalign_trap_q <= misalign_trap_d;
         cnt_q           <= cnt_d;
         addr_q          <= addr_d;
         pc4_q           <= pc4_d;
         funct3_q        <= funct3_d;
         rd_q            <= rd_d;
         reg_wr_q        <= reg_wr_d;
         wb_sel_q        <= wb_sel_d;
         is_load_q       <= is_load_d;
      end
   end

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Testbench for lsu_wb_stage: randomized ALU, load and store traffic checked
// against a behavioural model, plus timeout, reset-while-busy and alignment cases.
module tb_lsu_wb_stage;

   localparam int TO = 16;

   logic        clk;
   logic        rst;
   logic        reg_wr, wr_en, rd_en, mem_ack;
   logic [1:0]  wb_sel;
   logic [2:0]  funct3;
   logic [4:0]  rd_addr;
   logic [31:0] alu_result, rs2_data, pc, mem_rdata;
   logic        mem_req, mem_we, stall, rf_we, bus_err, misalign_trap;
   logic [31:0] mem_addr, mem_wdata, rf_wdata;
   logic [3:0]  mem_be;
   logic [4:0]  rf_waddr;

   int total = 0;
   int bad   = 0;

   lsu_wb_stage #(
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (5)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .reg_wr        (reg_wr),
      .wr_en         (wr_en),
      .rd_en         (rd_en),
      .wb_sel        (wb_sel),
      .funct3        (funct3),
      .rd_addr       (rd_addr),
      .alu_result    (alu_result),
      .rs2_data      (rs2_data),
      .pc            (pc),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_be        (mem_be),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ack       (mem_ack),
      .stall         (stall),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .bus_err       (bus_err),
      .misalign_trap (misalign_trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
      int unsigned a = addr % 4;
      case (f3 % 4)
         0:       return 4'(1 << a);
         1:       return 4'(3 << ((a / 2) * 2));
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3 % 4)
         0:       return (d & 32'hFF) * 32'h0101_0101;
         1:       return (d & 32'hFFFF) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] d);
      int unsigned sh;
      logic [31:0] v;
      case (f3)
         0, 4: begin
            sh = addr % 4;
            v  = (d >> (8 * sh)) & 32'hFF;
            if (f3 == 0 && v >= 128) v = v + 32'hFFFF_FF00;
         end
         1, 5: begin
            sh = ((addr % 4) / 2) * 2;
            v  = (d >> (8 * sh)) & 32'hFFFF;
            if (f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000;
         end
         default: v = d;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] exp_wb(input logic [1:0] sel, input logic [31:0] alu,
                                          input logic [31:0] pcv, input logic [31:0] ld);
      if (sel == 2'd1) return ld;
      if (sel == 2'd2) return pcv + 32'd4;
      return alu;
   endfunction

`ifdef MISALIGN_TRAP_EN
   function automatic logic [31:0] aligned(input logic [2:0] f3, input logic [31:0] addr);
      if (f3 % 4 == 0) return addr;
      if (f3 % 4 == 1) return addr & 32'hFFFF_FFFE;
      return addr & 32'hFFFF_FFFC;
   endfunction
`endif

   task automatic drive_idle();
      reg_wr     = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      mem_ack    = 1'b0;
      wb_sel     = 2'($urandom);
      funct3     = 3'($urandom);
      rd_addr    = 5'($urandom);
      alu_result = $urandom;
      rs2_data   = $urandom;
      pc         = $urandom;
      mem_rdata  = $urandom;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [110:0] snap;
      drive_idle();
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      snap = {mem_req, mem_we, mem_addr, mem_be, mem_wdata, rf_we, rf_waddr, rf_wdata,
              bus_err, misalign_trap, stall};
      total++;
      if (snap !== '0) begin
         bad++;
         $display("FAIL reset_async: got %h want 0", snap);
      end
      repeat (2) @(posedge clk);
      #1;
      snap = {mem_req, mem_we, mem_addr, mem_be, mem_wdata, rf_we, rf_waddr, rf_wdata,
              bus_err, misalign_trap, stall};
      total++;
      if (snap !== '0) begin
         bad++;
         $display("FAIL reset_held: got %h want 0", snap);
      end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_alu();
      logic        exp_we;
      logic [31:0] exp_d;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         drive_idle();
         if (i == 0) begin
            reg_wr = 1'b1; wb_sel = 2'd0; alu_result = 32'h1234; rd_addr = 5'd5;
         end else if (i == 1) begin
            reg_wr = 1'b1; wb_sel = 2'd2; pc = 32'hFFFF_FFFC; rd_addr = 5'd1;
         end else begin
            reg_wr = 1'($urandom);
            case ($urandom_range(0, 2))
               0:       wb_sel = 2'd0;
               1:       wb_sel = 2'd2;
               default: wb_sel = 2'd3;
            endcase
            if ($urandom_range(0, 5) == 0) rd_addr = 5'd0;
         end
         exp_we = reg_wr && (rd_addr != 5'd0);
         exp_d  = exp_wb(wb_sel, alu_result, pc, 32'h0);
         #1;
         total++;
         if (stall !== 1'b0) begin
            bad++;
            $display("FAIL alu_stall[%0d]: got %b want 0", i, stall);
         end
         @(posedge clk);
         #1;
         total++;
         if ({rf_we, mem_req} !== {exp_we, 1'b0}) begin
            bad++;
            $display("FAIL alu_we[%0d]: got we=%b req=%b want we=%b req=0", i, rf_we, mem_req, exp_we);
         end
         if (exp_we) begin
            total++;
            if ({rf_waddr, rf_wdata} !== {rd_addr, exp_d}) begin
               bad++;
               $display("FAIL alu_wb[%0d]: got %0d/%h want %0d/%h", i, rf_waddr, rf_wdata, rd_addr, exp_d);
            end
         end
      end
   endtask

   task automatic test_load();
      logic        exp_we;
      logic [31:0] exp_d, exp_a, data;
      logic [3:0]  exp_b;
      int          lat;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         drive_idle();
         rd_en   = 1'b1;
         wr_en   = 1'b0;
         reg_wr  = 1'($urandom);
         wb_sel  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
         lat     = $urandom_range(0, 4);
         data    = $urandom;
         if (i == 0) begin
            funct3 = 3'b000; alu_result = 32'h103; reg_wr = 1'b1; rd_addr = 5'd9;
            wb_sel = 2'b01; lat = 3; data = 32'h80FF_0000;
         end
`ifdef MISALIGN_TRAP_EN
         alu_result = aligned(funct3, alu_result);
`endif
         exp_we = reg_wr && (rd_addr != 5'd0);
         exp_d  = exp_wb(wb_sel, alu_result, pc, exp_load(funct3, alu_result, data));
         exp_a  = alu_result & 32'hFFFF_FFFC;
         exp_b  = exp_be(funct3, alu_result);
         #1;
         total++;
         if (stall !== 1'b1) begin
            bad++;
            $display("FAIL ld_issue_stall[%0d]: got %b want 1", i, stall);
         end
         @(posedge clk);
         #1;
         total++;
         if ({mem_req, mem_we, mem_addr, mem_be, rf_we} !== {1'b1, 1'b0, exp_a, exp_b, 1'b0}) begin
            bad++;
            $display("FAIL ld_bus[%0d]: got req=%b we=%b a=%h be=%b rfwe=%b want 1 0 %h %b 0",
                     i, mem_req, mem_we, mem_addr, mem_be, rf_we, exp_a, exp_b);
         end
         for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            mem_rdata = $urandom;
            #1;
            total++;
            if ({stall, mem_req, mem_addr, mem_be} !== {1'b1, 1'b1, exp_a, exp_b}) begin
               bad++;
               $display("FAIL ld_wait[%0d.%0d]: got stall=%b req=%b a=%h be=%b", i, k, stall, mem_req, mem_addr, mem_be);
            end
            @(posedge clk);
         end
         @(negedge clk);
         mem_ack   = 1'b1;
         mem_rdata = data;
         #1;
         total++;
         if (stall !== 1'b0) begin
            bad++;
            $display("FAIL ld_ack_stall[%0d]: got %b want 0", i, stall);
         end
         @(posedge clk);
         #1;
         total++;
         if ({mem_req, rf_we, bus_err} !== {1'b0, exp_we, 1'b0}) begin
            bad++;
            $display("FAIL ld_done[%0d]: got req=%b we=%b err=%b want 0 %b 0", i, mem_req, rf_we, bus_err, exp_we);
         end
         if (exp_we) begin
            total++;
            if ({rf_waddr, rf_wdata} !== {rd_addr, exp_d}) begin
               bad++;
               $display("FAIL ld_wb[%0d]: got %0d/%h want %0d/%h", i, rf_waddr, rf_wdata, rd_addr, exp_d);
            end
         end
      end
   endtask

   task automatic test_store();
      logic [31:0] exp_a, exp_w;
      logic [3:0]  exp_b;
      int          lat;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive_idle();
         wr_en   = 1'b1;
         rd_en   = 1'($urandom);
         reg_wr  = 1'b1;
         rd_addr = 5'($urandom_range(1, 31));
         funct3  = 3'($urandom_range(0, 2));
         lat     = $urandom_range(0, 4);
         if (i == 0) begin
            funct3 = 3'b001; alu_result = 32'h202; rs2_data = 32'h0000_ABCD;
         end
`ifdef MISALIGN_TRAP_EN
         alu_result = aligned(funct3, alu_result);
`endif
         exp_a = alu_result & 32'hFFFF_FFFC;
         exp_b = exp_be(funct3, alu_result);
         exp_w = exp_wdata(funct3, rs2_data);
         #1;
         total++;
         if (stall !== 1'b1) begin
            bad++;
            $display("FAIL st_issue_stall[%0d]: got %b want 1", i, stall);
         end
         @(posedge clk);
         #1;
         total++;
         if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, rf_we} !==
             {1'b1, 1'b1, exp_a, exp_b, exp_w, 1'b0}) begin
            bad++;
            $display("FAIL st_bus[%0d]: got req=%b we=%b a=%h be=%b d=%h rfwe=%b want 1 1 %h %b %h 0",
                     i, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rf_we, exp_a, exp_b, exp_w);
         end
         for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            #1;
            total++;
            if ({stall, mem_req, mem_wdata, mem_be, rf_we} !== {1'b1, 1'b1, exp_w, exp_b, 1'b0}) begin
               bad++;
               $display("FAIL st_wait[%0d.%0d]: got stall=%b req=%b d=%h be=%b rfwe=%b", i, k, stall, mem_req, mem_wdata, mem_be, rf_we);
            end
            @(posedge clk);
         end
         @(negedge clk);
         mem_ack = 1'b1;
         @(posedge clk);
         #1;
         total++;
         if ({mem_req, rf_we, bus_err} !== 3'b000) begin
            bad++;
            $display("FAIL st_done[%0d]: got req=%b we=%b err=%b want 0 0 0", i, mem_req, rf_we, bus_err);
         end
      end
   endtask

   task automatic test_timeout();
      @(negedge clk);
      drive_idle();
      rd_en = 1'b1; funct3 = 3'b010; alu_result = 32'h400; reg_wr = 1'b1; rd_addr = 5'd3; wb_sel = 2'b01;
      @(posedge clk);
      #1;
      total++;
      if (mem_req !== 1'b1) begin
         bad++;
         $display("FAIL to_issue: got req=%b want 1", mem_req);
      end
      for (int k = 0; k < TO; k++) begin
         @(negedge clk);
         #1;
         total++;
         if ({stall, mem_req, bus_err} !== {(k < TO - 1), 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL to_wait[%0d]: got stall=%b req=%b err=%b want %b 1 0", k, stall, mem_req, bus_err, (k < TO - 1));
         end
         @(posedge clk);
      end
      #1;
      total++;
      if ({mem_req, bus_err, rf_we} !== 3'b010) begin
         bad++;
         $display("FAIL to_abort: got req=%b err=%b we=%b want 0 1 0", mem_req, bus_err, rf_we);
      end
      @(negedge clk);
      drive_idle();
      mem_ack = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({mem_req, bus_err, rf_we} !== 3'b000) begin
         bad++;
         $display("FAIL to_after: got req=%b err=%b we=%b want 0 0 0", mem_req, bus_err, rf_we);
      end
   endtask

   task automatic test_reset_busy();
      @(negedge clk);
      drive_idle();
      rd_en = 1'b1; funct3 = 3'b010; alu_result = 32'h500; reg_wr = 1'b1; rd_addr = 5'd4; wb_sel = 2'b01;
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({mem_req, stall, rf_we, bus_err} !== 4'b0000) begin
         bad++;
         $display("FAIL rst_busy: got req=%b stall=%b we=%b err=%b want 0", mem_req, stall, rf_we, bus_err);
      end
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
      mem_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({mem_req, stall, rf_we, bus_err} !== 4'b0000) begin
         bad++;
         $display("FAIL rst_late_ack: got req=%b stall=%b we=%b err=%b want 0", mem_req, stall, rf_we, bus_err);
      end
   endtask

   task automatic test_misalign();
      logic [31:0] data;
      data = $urandom;
      @(negedge clk);
      drive_idle();
      rd_en = 1'b1; funct3 = 3'b010; alu_result = 32'h301; reg_wr = 1'b1; rd_addr = 5'd7; wb_sel = 2'b01;
`ifdef MISALIGN_TRAP_EN
      #1;
      total++;
      if (stall !== 1'b0) begin
         bad++;
         $display("FAIL mis_stall: got %b want 0", stall);
      end
      @(posedge clk);
      #1;
      total++;
      if ({mem_req, misalign_trap, rf_we} !== 3'b010) begin
         bad++;
         $display("FAIL mis_trap: got req=%b trap=%b we=%b want 0 1 0", mem_req, misalign_trap, rf_we);
      end
      @(negedge clk);
      drive_idle();
      @(posedge clk);
      #1;
      total++;
      if ({mem_req, misalign_trap} !== 2'b00) begin
         bad++;
         $display("FAIL mis_pulse: got req=%b trap=%b want 0 0", mem_req, misalign_trap);
      end
      @(negedge clk);
      wr_en = 1'b1; funct3 = 3'b001; alu_result = 32'h203;
      @(posedge clk);
      #1;
      total++;
      if ({mem_req, misalign_trap, rf_we} !== 3'b010) begin
         bad++;
         $display("FAIL mis_sh: got req=%b trap=%b we=%b want 0 1 0", mem_req, misalign_trap, rf_we);
      end
`else
      #1;
      total++;
      if (stall !== 1'b1) begin
         bad++;
         $display("FAIL mis_stall: got %b want 1", stall);
      end
      @(posedge clk);
      #1;
      total++;
      if ({mem_req, mem_addr, mem_be, misalign_trap} !== {1'b1, 32'h300, 4'hF, 1'b0}) begin
         bad++;
         $display("FAIL mis_lw_bus: got req=%b a=%h be=%b trap=%b want 1 300 1111 0", mem_req, mem_addr, mem_be, misalign_trap);
      end
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = data;
      @(posedge clk);
      #1;
      total++;
      if ({rf_we, rf_wdata} !== {1'b1, data}) begin
         bad++;
         $display("FAIL mis_lw_wb: got we=%b d=%h want 1 %h", rf_we, rf_wdata, data);
      end
      @(negedge clk);
      mem_ack = 1'b0; funct3 = 3'b101; alu_result = 32'h203; rd_addr = 5'd8;
      @(posedge clk);
      #1;
      total++;
      if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h200, 4'b1100}) begin
         bad++;
         $display("FAIL mis_lhu_bus: got req=%b a=%h be=%b want 1 200 1100", mem_req, mem_addr, mem_be);
      end
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'h8001_1234;
      @(posedge clk);
      #1;
      total++;
      if ({rf_we, rf_wdata, misalign_trap} !== {1'b1, 32'h0000_8001, 1'b0}) begin
         bad++;
         $display("FAIL mis_lhu_wb: got we=%b d=%h trap=%b want 1 00008001 0", rf_we, rf_wdata, misalign_trap);
      end
`endif
      @(negedge clk);
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_timeout();
      test_reset_busy();
      test_misalign();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_wb_stage.md
Name: lsu_wb_stage

Overview:
- Memory/writeback stage of the 3-stage pipeline; consumes the registered control bundle (reg_wr, wr_en, rd_en, wb_sel) plus datapath values from the execute stage.
- Runs loads and stores over a req/ack data-memory bus, stalling upstream until the access completes.
- Aligns and sign-extends load data, selects the writeback source and drives registered register-file write signals.

Parameters:
- TIMEOUT_CYCLES, 16, max BUSY cycles waiting for mem_ack before abort (≥1)
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- reg_wr  in  1  instruction writes rd
- wr_en  in  1  store
- rd_en  in  1  load (ignored when wr_en=1)
- wb_sel  in  2  00 alu, 01 load data, 10 pc+4, 11 alu
- funct3  in  3  access size/sign
- rd_addr  in  5  destination register
- alu_result  in  32  result / effective address
- rs2_data  in  32  store data
- pc  in  32  instruction PC
- mem_req  out  1  bus request, registered
- mem_we  out  1  1=store
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  load data, valid with mem_ack
- mem_ack  in  1  single-cycle completion
- stall  out  1  hold upstream stage
- rf_we  out  1  register write enable, registered
- rf_waddr  out  5  register write address, registered
- rf_wdata  out  32  register write data, registered
- bus_err  out  1  one-cycle pulse on timeout
- misalign_trap  out  1  one-cycle pulse (see Optional Feature)

Behaviour:
- Reset (async, immediate): state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, rf_we, rf_waddr, rf_wdata, bus_err, misalign_trap, counter all 0.
- Reset mid-access drops mem_req at once; a later ack is ignored.
- States: IDLE, BUSY.
- IDLE, no memory op: next edge rf_we <= reg_wr && rd_addr!=0; rf_waddr <= rd_addr; rf_wdata <= wb_sel-selected value (pc+4 computed mod 2^32). stall=0. Latency 1.
- IDLE, memory op (wr_en|rd_en): stall=1 combinationally.
  - Capture addr, funct3, rd, reg_wr, wb_sel and the load/store flag.
  - Drive mem_* and set mem_req=1 at next edge; go BUSY. rf_we=0 that edge.
- BUSY: mem_req and bus fields held stable until ack. stall = !mem_ack. Counter increments each cycle without ack.
  - On mem_ack: mem_req <= 0; go IDLE.
    - Load: rf_we <= reg_wr && rd!=0, rf_wdata <= extracted data (wb_sel 01), otherwise selected per wb_sel.
    - Store: rf_we <= 0.
  - Counter reaching TIMEOUT_CYCLES with no ack: mem_req <= 0; bus_err pulses 1 cycle; rf_we <= 0; stall=0 that cycle; go IDLE.
- Upstream holds inputs while stall=1; after release, the next instruction arrives in IDLE.
- Store enables (addr[1:0]=a):
  - SB (000): be=0001<<a, wdata={4{rs2[7:0]}}
  - SH (001): be=0011<<(2*a[1]), wdata={2{rs2[15:0]}}
  - SW (010): be=1111
- Load extract:
  - LB 000 / LBU 100: byte a, sign-/zero-extended.
  - LH 001 / LHU 101: half a[1], sign-/zero-extended.
  - LW 010: full word.
  - Other funct3: treated as word.
- Ack arriving while IDLE is ignored.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: misaligned half (addr[0]=1) or word (addr[1:0]!=0) in IDLE issues no bus access and stall=0. Next edge: misalign_trap pulses 1 cycle, rf_we=0, state stays IDLE.
- Undefined: no check is made. Low address bits are treated as forced aligned (half: a[0]=0; word: a=00) for be and extraction. misalign_trap is tied 0.

Test Plan:
- ADD-type, reg_wr=1, wb_sel=00, alu=0x1234, rd=5 -> next cycle rf_we=1, waddr=5, wdata=0x1234, stall=0, mem_req=0.
- LB addr 0x103, mem_rdata=0x80FF_0000, ack 3 cycles after mem_req rises -> stall held until ack cycle, be=1000, wdata to rd = 0xFFFFFF80.
- SH addr 0x202, rs2=0xABCD -> mem_addr=0x200, be=1100, wdata=0xABCDABCD, mem_we=1, rf_we stays 0.
- Load, no ack for TIMEOUT_CYCLES=16 -> mem_req falls, bus_err single pulse, stall released, rf_we=0.
- Assert rst while BUSY -> mem_req, stall, rf_we 0 immediately; later ack has no effect.
- LW addr 0x301: with MISALIGN_TRAP_EN -> no mem_req, misalign_trap one pulse; without -> access at 0x300, be=1111.
